// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch redirects and
// data-memory freezes, with a watchdog on memory wait states and saturating
// event counters.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   RUN      | normal flow; a new un-ready data access freezes the pipe
//   MEM_WAIT | data access outstanding; pipe frozen until dmem_ready
module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [0:0] RUN      = 1'b0;
  localparam logic [0:0] MEM_WAIT = 1'b1;

  localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_SAT   = {CNT_W{1'b1}};

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              freeze;
  logic              rs1_hit;
  logic              rs2_hit;
  logic              stall_evt;
  logic              flush_evt;
  logic              freeze_evt;

  // Load-use detection: the ID instruction needs a register the EX load has not produced yet
  always_comb begin
    rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    load_use = ex_mem_read && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
  end

  // Freeze whenever a data access is outstanding and memory is not ready this cycle
  always_comb begin
    freeze = 1'b0;
    if (state == MEM_WAIT) begin
      freeze = !dmem_ready;
    end else begin
      freeze = dmem_req && !dmem_ready;
    end
  end

  // Next-state logic; dmem_req is not looked at while waiting since the access is held
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Prioritised pipeline control: reset, freeze, redirect, load-use bubble, normal flow
  always_comb begin
    pc_write    = 1'b1;
    pc_sel      = 1'b0;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_stall = 1'b0;
    pipe_hold   = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_stall = 1'b1;
    end else if (freeze) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (ex_branch_taken) begin
      // The squashed ID instruction makes any load-use hazard irrelevant
      pc_sel      = 1'b1;
      if_id_flush = 1'b1;
      id_ex_stall = 1'b1;
    end else if (load_use) begin
      // One bubble suffices: the load moves on to MEM next cycle
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_stall = 1'b1;
    end
  end

  // Watchdog on memory wait cycles; the error is sticky but does not abort the wait
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (state == RUN) begin
      wait_cnt <= '0;
    end else if (!dmem_ready) begin
      if (wait_cnt == WAIT_LAST) begin
        mem_timeout <= 1'b1;
      end
      if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + WAIT_ONE;
      end
    end
  end

  // Event strobes matching the control priority above
  always_comb begin
    freeze_evt = !reset && freeze;
    flush_evt  = !reset && !freeze && ex_branch_taken;
    stall_evt  = !reset && !freeze && !ex_branch_taken && load_use;
  end

  // Load-use bubble counter, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_evt && (stall_cnt != CNT_SAT)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  // Redirect counter, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt <= '0;
    end else if (flush_evt && (flush_cnt != CNT_SAT)) begin
      flush_cnt <= flush_cnt + CNT_ONE;
    end
  end

  // Frozen-cycle counter, saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      freeze_cnt <= '0;
    end else if (freeze_evt && (freeze_cnt != CNT_SAT)) begin
      freeze_cnt <= freeze_cnt + CNT_ONE;
    end
  end

endmodule
